// File: rtl/count_seq_ctrl.sv
// Start/pause/clear sequencer for a prescaled up/down display counter with press conditioning.
// Define HEX_DECODE_EN to build the seven-segment decoder on hex; otherwise hex is blank.
module count_seq_ctrl #(
    parameter int PRESCALE = 50_000_000,
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_start_n,
    input  logic             key_clear_n,
    input  logic             sw_down,
    input  logic             sw_reload,
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             running,
    output logic             done,
    output logic [6:0]       hex
);

    localparam int              PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PS_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] TERM    = WIDTH'(TERMINAL);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [PW-1:0]    presc_reg, presc_next;
    logic             dir_reg, dir_next;
    logic             running_reg;
    logic             done_reg;

    logic [1:0]       key_n;
    logic [1:0]       press;
    logic             start_press;
    logic             clear_press;

    logic             step_now;
    logic [WIDTH-1:0] end_val;
    logic [WIDTH-1:0] load_dir;
    logic [WIDTH-1:0] load_live;
    logic [WIDTH-1:0] stepped;
    logic             hits_end;

    // Bit 0 is the start key, bit 1 the clear key; each gets its own s1->s2->s3 chain.
    assign key_n = {key_clear_n, key_start_n};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            logic [2:0] sync_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg <= 3'b111;
                end else begin
                    sync_reg <= {sync_reg[1:0], key_n[gi]};
                end
            end

            assign press[gi] = sync_reg[2] & ~sync_reg[1];
        end
    endgenerate

    assign start_press = press[0];
    assign clear_press = press[1];

    assign step_now  = (state_reg == RUN) && (presc_reg == PS_LAST);
    assign end_val   = dir_reg ? '0 : TERM;
    assign load_dir  = dir_reg ? TERM : '0;
    assign load_live = sw_down ? TERM : '0;

    // Value count takes on a step edge; sitting on the end value either wraps or holds.
    always_comb begin
        if (count_reg == end_val) begin
            stepped = sw_reload ? load_dir : end_val;
        end else if (dir_reg) begin
            stepped = count_reg - ONE;
        end else begin
            stepped = count_reg + ONE;
        end
    end

    assign hits_end = (stepped == end_val) && !sw_reload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            presc_reg   <= '0;
            dir_reg     <= 1'b0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            presc_reg   <= presc_next;
            dir_reg     <= dir_next;
            running_reg <= (state_next == RUN);
            done_reg    <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        presc_next = presc_reg;
        dir_next   = dir_reg;

        if (clear_press) begin
            state_next = IDLE;
            count_next = load_live;
            presc_next = '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start_press) begin
                        state_next = RUN;
                        dir_next   = sw_down;
                        count_next = load_live;
                        presc_next = '0;
                    end
                end
                RUN: begin
                    if (step_now) begin
                        presc_next = '0;
                        count_next = stepped;
                    end else begin
                        presc_next = presc_reg + PS_ONE;
                    end
                    // Reaching the end without reload takes precedence over a pause request.
                    if (step_now && hits_end) begin
                        state_next = DONE;
                    end else if (start_press) begin
                        state_next = PAUSE;
                    end
                end
                PAUSE: begin
                    if (start_press) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign count   = count_reg;
    assign step    = step_now;
    assign running = running_reg;
    assign done    = done_reg;

`ifdef HEX_DECODE_EN
    logic [3:0] hex_nib;

    assign hex_nib = 4'(count_reg);

    always_comb begin
        case (hex_nib)
            4'h0: hex = 7'b1000000;
            4'h1: hex = 7'b1111001;
            4'h2: hex = 7'b0100100;
            4'h3: hex = 7'b0110000;
            4'h4: hex = 7'b0011001;
            4'h5: hex = 7'b0010010;
            4'h6: hex = 7'b0000010;
            4'h7: hex = 7'b1111000;
            4'h8: hex = 7'b0000000;
            4'h9: hex = 7'b0010000;
            4'hA: hex = 7'b0001000;
            4'hB: hex = 7'b0000011;
            4'hC: hex = 7'b1000110;
            4'hD: hex = 7'b0100001;
            4'hE: hex = 7'b0000110;
            default: hex = 7'b0001110;
        endcase
    end
`else
    assign hex = 7'b1111111;
`endif

endmodule
